// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the input conditioner.
// State enum, default parameters and a counter width helper.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_CHK_HIGH,
        S_HIGH,
        S_CHK_LOW
    } state_t;

    localparam int N_CH_DEF        = 4;
    localparam int DEBOUNCE_P_DEF  = 300;
    localparam int HOLD_T_DEF      = 2000;
    localparam int SYNC_STAGES_DEF = 2;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input: synchronizer, debounce FSM, edge and hold pulses.
// A release glitch returns to S_HIGH without touching the hold counter.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_P  = DEBOUNCE_P_DEF,
    parameter int HOLD_T      = HOLD_T_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int DW = cnt_width(DEBOUNCE_P - 1);
    localparam int HW = cnt_width(HOLD_T);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_P - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_T);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q, state_d;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, fall_q, hold_q;
    logic                   hold_d;
    logic                   enter_high;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchronizer chain for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    // Debounce next-state: candidate level must hold for DEBOUNCE_P cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOW: begin
                if (sync) begin
                    state_d = S_CHK_HIGH;
                    cnt_d   = '0;
                end
            end
            S_CHK_HIGH: begin
                if (!sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_HIGH: begin
                if (!sync) begin
                    state_d = S_CHK_LOW;
                    cnt_d   = '0;
                end
            end
            S_CHK_LOW: begin
                if (sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Level, hold counter and pulse qualification from the next state.
    always_comb begin
        level_d    = (state_d == S_HIGH) || (state_d == S_CHK_LOW);
        enter_high = (state_q == S_CHK_HIGH) && (state_d == S_HIGH);
        hcnt_d     = hcnt_q;
        if (enter_high)
            hcnt_d = '0;
        else if (level_q && (hcnt_q != HOLD_MAX))
            hcnt_d = hcnt_q + HW'(1);
        hold_d = (hcnt_d == HOLD_MAX) && (hcnt_q != HOLD_MAX);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
            hold_q  <= hold_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign hold  = hold_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner top.
// Replicates one independent debounce channel per input bit.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int DEBOUNCE_P  = DEBOUNCE_P_DEF,
    parameter int HOLD_T      = HOLD_T_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_P  (DEBOUNCE_P),
            .HOLD_T      (HOLD_T),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .din   (din[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .hold  (hold[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner.
// Run-length reference model feeds a queue checked by a monitor.
module tb_input_conditioner;

    localparam int NC = 4;
    localparam int DP = 4;
    localparam int HT = 10;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NC-1:0] din = '0;
    logic [NC-1:0] level, rise, fall, hold;

    typedef struct packed {
        logic [NC-1:0] level;
        logic [NC-1:0] rise;
        logic [NC-1:0] fall;
        logic [NC-1:0] hold;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    input_conditioner #(
        .N_CH        (NC),
        .DEBOUNCE_P  (DP),
        .HOLD_T      (HT),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .hold  (hold)
    );

    always #5 clk = ~clk;

    // Reference: level flips after DP+1 consecutive edges where the
    // SS-edge-delayed input differs from it; hold fires HT cycles after rise.
    initial begin : model
        logic [NC-1:0] hist[$];
        logic [NC-1:0] lvl;
        logic [NC-1:0] s;
        int            run[NC];
        int            age[NC];
        obs_t          e;
        lvl = '0;
        repeat (SS) hist.push_back('0);
        for (int c = 0; c < NC; c++) begin
            run[c] = 0;
            age[c] = 0;
        end
        forever begin
            @(posedge clk);
            e = '0;
            if (!rst) begin
                lvl = '0;
                hist.delete();
                repeat (SS) hist.push_back('0);
                for (int c = 0; c < NC; c++) begin
                    run[c] = 0;
                    age[c] = 0;
                end
            end else begin
                s = hist[SS-1];
                for (int c = 0; c < NC; c++) begin
                    if (lvl[c] && age[c] < HT) begin
                        age[c]++;
                        if (age[c] == HT) e.hold[c] = 1'b1;
                    end
                    if (s[c] != lvl[c]) begin
                        run[c]++;
                        if (run[c] == DP + 1) begin
                            lvl[c] = ~lvl[c];
                            run[c] = 0;
                            if (lvl[c]) begin
                                e.rise[c] = 1'b1;
                                age[c]    = 0;
                            end else begin
                                e.fall[c] = 1'b1;
                            end
                        end
                    end else begin
                        run[c] = 0;
                    end
                end
                hist.push_front(din);
                void'(hist.pop_back());
            end
            e.level = lvl;
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle presents one observation to compare.
    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            a = {level, rise, fall, hold};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t: got %h, no expected entry",
                         $time, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t: got lvl=%b rise=%b fall=%b hold=%b want lvl=%b rise=%b fall=%b hold=%b",
                             $time, a.level, a.rise, a.fall, a.hold,
                             e.level, e.rise, e.fall, e.hold);
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        n_checks++;
        if ({level, rise, fall, hold} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs %h, want 0", nm,
                     {level, rise, fall, hold});
        end
    endtask

    // Call right after changing an input at a negedge; counts edges after
    // the first sampling edge until the selected output of channel c is 1.
    task automatic wait_pulse(input string nm, input int c,
                              input bit use_rise, input int want);
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        @(posedge clk);
        while (!hit && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            hit = use_rise ? rise[c] : level[c];
        end
        n_checks++;
        if (!hit || n != want) begin
            n_fail++;
            $display("FAIL %s: seen=%0b after %0d cycles, want 1 after %0d",
                     nm, hit, n, want);
        end
    endtask

    initial begin : driver
        tick(3);
        check_zero("reset_idle");
        rst = 1'b1;
        tick(4);

        @(negedge clk) din[0] = 1'b1;
        wait_pulse("ch0_level_latency", 0, 1'b0, 6);
        tick(5);

        din[1] = 1'b1;
        tick(3);
        din[1] = 1'b0;
        tick(10);

        din[2] = 1'b1;
        tick(26);
        din[2] = 1'b0;
        tick(12);

        din[0] = 1'b0;
        tick(10);
        din[0] = 1'b1;
        din[3] = 1'b1;
        tick(15);
        din[0] = 1'b0;
        din[3] = 1'b0;
        tick(10);

        din[0] = 1'b1;
        tick(3);
        rst = 1'b0;
        #1;
        check_zero("reset_async");
        tick(3);
        check_zero("reset_held");
        rst = 1'b1;
        wait_pulse("ch0_rise_after_reset", 0, 1'b1, 6);
        tick(3);
        din[0] = 1'b0;
        tick(10);

        din[1] = 1'b1;
        tick(8);
        din[1] = 1'b0;
        tick(2);
        din[1] = 1'b1;
        tick(15);
        din[1] = 1'b0;
        tick(10);

        repeat (1500) begin
            @(negedge clk);
            rst = 1'b1;
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 7) == 0) din[c] = ~din[c];
            if ($urandom_range(0, 299) == 0) rst = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        din = '0;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent input channels.
REQ-002 The block SHALL have parameter DEBOUNCE_P, default 300, giving the stable-input period in clk cycles (1 ms each at 1 kHz); legal range 1 or more.
REQ-003 The block SHALL have parameter HOLD_T, default 2000, giving the long-press period in clk cycles; legal range 1 or more.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth; legal range 2 or more.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, driven by the divided 1 kHz clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port din, input, N_CH bits: raw active-high inputs (push buttons, infrared sensor), asynchronous to clk.
REQ-008 The block SHALL have port level, output, N_CH bits: debounced stable level per channel.
REQ-009 The block SHALL have port rise, output, N_CH bits: one-cycle pulse when level goes 0->1.
REQ-010 The block SHALL have port fall, output, N_CH bits: one-cycle pulse when level goes 1->0.
REQ-011 The block SHALL have port hold, output, N_CH bits: one-cycle pulse when level has been 1 for HOLD_T cycles.

Function
REQ-012 Each channel SHALL pass din through a SYNC_STAGES-deep flip-flop chain; all later logic SHALL use only the last stage (sync).
REQ-013 Each channel SHALL run a 4-state FSM: S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW.
REQ-014 S_LOW with sync=1 SHALL go to S_CHK_HIGH with the debounce counter cleared to 0; S_HIGH with sync=0 SHALL go to S_CHK_LOW with the counter cleared.
REQ-015 In a CHK state with sync equal to the candidate level, the counter SHALL increment; when it reaches DEBOUNCE_P-1 on a matching cycle, the FSM SHALL commit to S_HIGH or S_LOW on the next edge.
REQ-016 In a CHK state with sync not equal to the candidate, the FSM SHALL return to the previous stable state, clear the counter and emit no pulse (glitch rejection).
REQ-017 level SHALL be 1 exactly in S_HIGH and S_CHK_LOW, and registered.
REQ-018 For a din step held stable, level SHALL change exactly SYNC_STAGES + DEBOUNCE_P clk cycles after the first clk edge that samples the new din value.
REQ-019 rise and fall SHALL be registered and asserted for exactly the first cycle in which level shows its new value.
REQ-020 A hold counter SHALL clear on entry to S_HIGH, increment each cycle level=1 including S_CHK_LOW, and saturate at HOLD_T; hold SHALL pulse once in the cycle the counter reaches HOLD_T.
REQ-021 hold SHALL not repeat until level has fallen and risen again; a rejected release glitch in S_CHK_LOW SHALL not clear the hold counter.
REQ-022 Counter widths SHALL be $clog2(max value + 1); no counter SHALL wrap.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 While rst=0, all sync flops, counters and outputs SHALL be 0 and every FSM SHALL be in S_LOW, regardless of clk.
REQ-025 After rst deasserts with din held 1, the channel SHALL perform a full debounce and then emit rise; a press in progress at reset SHALL not be remembered.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW) and the default parameter constants.
REQ-027 The per-channel logic SHALL be a sub-module debounce_channel, instantiated N_CH times with a generate loop.

Verification (bench: N_CH=4, DEBOUNCE_P=4, HOLD_T=10, SYNC_STAGES=2)
REQ-028 din[0] 0->1 held -> level[0]=1 and rise[0] 1-cycle pulse exactly 6 cycles after the first sampling edge; other channels stay 0.
REQ-029 din[1] high for 3 cycles then low -> level[1], rise[1], fall[1] all stay 0.
REQ-030 din[2] held high 20 cycles after level rises -> exactly one hold[2] pulse, 10 cycles after level[2] rose; no second pulse.
REQ-031 din[0] and din[3] rise on the same edge -> rise[0] and rise[3] pulse in the same cycle; later release of both -> fall[0] and fall[3] pulse in the same cycle.
REQ-032 rst=0 mid-debounce with din[0]=1, then rst=1 -> all outputs 0 during reset; rise[0] 6 cycles after release.
REQ-033 level[1]=1 with a 2-cycle low glitch -> no fall[1]; hold[1] timing unchanged.
